// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor.
// Operands are captured on start, then added DIGIT bits per clock, LSB slice
// first, with the slice carry rippling through a one-bit register. The full
// WIDTH-bit result, carry-out and signed overflow are registered together on
// the edge that processes the last slice, followed by a one-cycle DONE state.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d; // partial result, filled slice by slice
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  int               slice_lo;
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic [DIGIT:0]   slice_full;
  logic             carry_into_msb;
  logic             last_slice;

  // Current slice adder: selects the slice addressed by the counter and adds it with the running carry.
  always_comb begin
    slice_lo   = int'(cnt_q) * DIGIT;
    a_slice    = a_q[slice_lo +: DIGIT];
    b_slice    = b_q[slice_lo +: DIGIT];
    slice_full = {1'b0, a_slice} + {1'b0, b_slice} + (DIGIT + 1)'(carry_q);
    // Carry into the top bit is recovered from that bit's sum and its two inputs.
    carry_into_msb = slice_full[DIGIT-1] ^ a_slice[DIGIT-1] ^ b_slice[DIGIT-1];
    last_slice     = (cnt_q == CW'(N - 1));
  end

  // Next-state logic for the FSM, datapath and result registers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract is a + ~b + 1; cin only matters for add.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d[slice_lo +: DIGIT] = slice_full[DIGIT-1:0];
        carry_d = slice_full[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          sum_d   = acc_d;
          cout_d  = slice_full[DIGIT];
          ovf_d   = carry_into_msb ^ slice_full[DIGIT];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset that aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder: a 16/4 instance for directed scenarios,
// plus 8/1 and 8/8 instances swept against a behavioural reference model.
// Expected results are queued when an operation is accepted and popped on done.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance, WIDTH=16 DIGIT=4
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        ready, busy, done, cout, ovf;
  logic [15:0] sum;

  // Sweep instances share operand inputs, each has its own start
  logic [7:0] a8, b8;
  logic       sub8, cin8, start1, start8;
  logic       ready1, busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, input logic tsub);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] bb;
    exp_t        e;
    mask   = 16'((17'd1 << w) - 17'd1);
    bb     = tsub ? (~tb & mask) : tb;
    full   = {1'b0, ta} + {1'b0, bb} + {16'd0, (tsub ? 1'b1 : tcin)};
    e.sum  = full[15:0] & mask;
    e.cout = full[w];
    e.ovf  = (ta[w-1] == bb[w-1]) && (e.sum[w-1] != ta[w-1]);
    return e;
  endfunction

  // Drives one operation on the main instance (called #1 after an edge) and
  // waits for done. lat counts edges from acceptance to done; busy_cyc counts
  // sampled cycles with busy high.
  task automatic main_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input logic tsub, input exp_t e, output int lat, output int busy_cyc);
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(e);
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags got=%b want=100", {ready, busy, done});
    end
    total++;
    if ({sum, cout, ovf} !== 18'd0) begin
      bad++;
      $display("FAIL reset_result got sum=%h cout=%b ovf=%b want 0000/0/0", sum, cout, ovf);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  task automatic test_arith();
    vec_t v[5];
    int   lat, bc;
    exp_t got;
    v[0] = '{16'h0003, 16'h0001, 1'b0, 1'b0, '{16'h0004, 1'b0, 1'b0}};
    v[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    v[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      main_op(v[i].a, v[i].b, v[i].cin, v[i].sub, v[i].e, lat, bc);
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL arith%0d_latency got=%0d want=4", i, lat);
      end
      total++;
      if (bc !== 4) begin
        bad++;
        $display("FAIL arith%0d_busy_cycles got=%0d want=4", i, bc);
      end
      got = sb.pop_front();
      total++;
      if ({sum, cout, ovf} !== {got.sum, got.cout, got.ovf}) begin
        bad++;
        $display("FAIL arith%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, got.sum, got.cout, got.ovf);
      end
      @(posedge clk); #1;
      total++;
      if ({sum, ready, done} !== {got.sum, 2'b10}) begin
        bad++;
        $display("FAIL arith%0d_hold got sum=%h ready=%b done=%b want sum=%h ready=1 done=0",
                 i, sum, ready, done, got.sum);
      end
    end
  endtask

  task automatic test_protocol();
    int   lat;
    exp_t got;
    a = 16'h1234; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{16'h1335, 1'b0, 1'b0});
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL protocol_latency got=%0d want=4", lat);
    end
    got = sb.pop_front();
    total++;
    if ({sum, cout, ovf} !== {got.sum, got.cout, got.ovf}) begin
      bad++;
      $display("FAIL protocol_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, got.sum, got.cout, got.ovf);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL protocol_no_queue got ready=%b busy=%b want ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    int   done_seen;
    exp_t got;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{16'h0100, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb.delete();
    total++;
    if ({ready, busy, done, sum} !== {3'b100, 16'h0000}) begin
      bad++;
      $display("FAIL midrun_reset got ready=%b busy=%b done=%b sum=%h want 1/0/0/0000",
               ready, busy, done, sum);
    end
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL midrun_no_done got=%0d pulses want=0", done_seen);
    end
    a = 16'h0002; b = 16'h0003; cin = 1'b0; sub = 1'b0; start = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{16'h0005, 1'b0, 1'b0});
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_restart_accept got busy=%b want=1", busy);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    total++;
    if ({lat, sum} !== {32'd4, got.sum}) begin
      bad++;
      $display("FAIL midrun_restart_result got lat=%0d sum=%h want lat=4 sum=%h", lat, sum, got.sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    time  acc_t[$];
    logic prev_busy;
    exp_t got;
    int   dones;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    prev_busy = busy;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        acc_t.push_back($time);
        sb.push_back('{16'h0002, 1'b0, 1'b0});
      end
      if (done) begin
        dones++;
        got = sb.pop_front();
        total++;
        if (sum !== got.sum) begin
          bad++;
          $display("FAIL b2b_result%0d got=%h want=%h", dones, sum, got.sum);
        end
      end
      prev_busy = busy;
      if (i == 20) start = 1'b0;
    end
    total++;
    if (acc_t.size() !== 4) begin
      bad++;
      $display("FAIL b2b_accept_count got=%0d want=4", acc_t.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      total++;
      if (acc_t[i] - acc_t[i-1] !== 60) begin
        bad++;
        $display("FAIL b2b_spacing%0d got=%0t want=60", i, acc_t[i] - acc_t[i-1]);
      end
    end
    total++;
    if ({sb.size(), ready} !== {32'd0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_drain got pending=%0d ready=%b want 0/1", sb.size(), ready);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] pts[16];
    exp_t       got;
    int         lat, want_lat;
    logic [7:0] s;
    logic       c, o, d;
    pts = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h3C, 8'h55, 8'h7E,
            8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};
    for (int sel = 0; sel < 2; sel++) begin
      want_lat = (sel == 1) ? 1 : 8;
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          for (int m = 0; m < 4; m++) begin
            a8 = pts[ia]; b8 = pts[ib]; cin8 = m[0]; sub8 = m[1];
            if (sel == 1) start8 = 1'b1; else start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0; start8 = 1'b0;
            sb.push_back(model(8, {8'd0, pts[ia]}, {8'd0, pts[ib]}, m[0], m[1]));
            lat = 0;
            d = (sel == 1) ? done8 : done1;
            while (!d && lat < 20) begin
              @(posedge clk); #1;
              lat++;
              d = (sel == 1) ? done8 : done1;
            end
            s = (sel == 1) ? sum8 : sum1;
            c = (sel == 1) ? cout8 : cout1;
            o = (sel == 1) ? ovf8 : ovf1;
            got = sb.pop_front();
            total++;
            if (lat !== want_lat) begin
              bad++;
              $display("FAIL sweep_n%0d_latency a=%h b=%h got=%0d want=%0d", want_lat, a8, b8, lat, want_lat);
            end
            total++;
            if ({s, c, o} !== {got.sum[7:0], got.cout, got.ovf}) begin
              bad++;
              $display("FAIL sweep_n%0d a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                       want_lat, a8, b8, cin8, sub8, s, c, o, got.sum[7:0], got.cout, got.ovf);
            end
            @(posedge clk); #1;
          end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_arith();
    test_protocol();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
